icache_assoc: RTL and testbench

ICACHE_ASSOC -- requirements
Module: icache_assoc

---
 rtl/icache_assoc.sv | 233 +++++++++++++++++++++++
 tb/tb_icache_assoc.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/icache_assoc.sv
// icache_assoc: set-associative instruction cache with Wishbone line refill.
// Define ICACHE_PERF_CNT_EN to add the perf_hit/perf_miss counters.
module icache_assoc #(
    parameter int WAYS   = 4,
    parameter int IDX_W  = 5,
    parameter int OFF_W  = 2,
    parameter int ADDR_W = 16
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              mem_req,
    input  logic [ADDR_W-1:0] mem_addr,
    output logic              mem_ack,
    output logic [31:0]       mem_data,
    output logic              mem_err,
    input  logic              mem_flush,
    output logic              wb_cyc,
    output logic              wb_stb,
    output logic              wb_we,
    output logic [1:0]        wb_sel,
    output logic [15:0]       wb_adr,
    input  logic [15:0]       wb_i_dat,
    input  logic              wb_ack,
    input  logic              wb_err
`ifdef ICACHE_PERF_CNT_EN
    ,
    output logic [15:0]       perf_hit,
    output logic [15:0]       perf_miss
`endif
);
    localparam int TAG_W  = ADDR_W - IDX_W - OFF_W;
    localparam int SETS   = 1 << IDX_W;
    localparam int NW     = 1 << (OFF_W + 1);
    localparam int LINE_W = NW * 16;
    localparam int WAY_W  = (WAYS > 1) ? $clog2(WAYS) : 1;
    localparam logic [OFF_W:0] LAST_BEAT = (OFF_W + 1)'(NW - 1);

    typedef enum logic [1:0] {IDLE, LOOKUP, FILL} state_t;

    state_t                       state_q, state_d;
    logic [ADDR_W-1:0]            addr_q, addr_d;
    logic [OFF_W:0]               cnt_q, cnt_d;
    logic [LINE_W-1:0]            lbuf_q, lbuf_d;
    logic                         err_q, err_d;
    logic                         disc_q, disc_d;
    logic                         flush_prev_q, flush_prev_d;
    logic [WAY_W-1:0]             victim_q, victim_d;
    logic [WAYS-1:0][SETS-1:0]    valid_q, valid_d;
    logic [SETS-1:0][WAY_W-1:0]   rr_q, rr_d;

    logic [TAG_W-1:0]  tag_mem  [WAYS][SETS];
    logic [LINE_W-1:0] line_mem [WAYS][SETS];
    logic [TAG_W-1:0]  tag_rd   [WAYS];
    logic [LINE_W-1:0] line_rd  [WAYS];

    logic [IDX_W-1:0]  idx_q;
    logic [TAG_W-1:0]  tag_q;
    logic [OFF_W-1:0]  off_q;
    logic [IDX_W-1:0]  rd_idx;
    logic              rd_en;
    logic              wr_en;
    logic [WAYS-1:0]   hit_vec;
    logic              hit_any;
    logic [LINE_W-1:0] hit_line;
    logic [LINE_W-1:0] fill_line;
    logic [WAY_W-1:0]  vic;
    logic              beat;
    logic [ADDR_W:0]   wb_full;

    assign idx_q  = addr_q[OFF_W+IDX_W-1:OFF_W];
    assign tag_q  = addr_q[ADDR_W-1:OFF_W+IDX_W];
    assign off_q  = addr_q[OFF_W-1:0];
    assign rd_idx = mem_addr[OFF_W+IDX_W-1:OFF_W];
    assign rd_en  = (state_q == IDLE) && mem_req;

    assign wb_we   = 1'b0;
    assign wb_sel  = 2'b11;
    assign wb_full = {addr_q[ADDR_W-1:OFF_W], cnt_q};
    assign wb_adr  = 16'(wb_full);
    assign beat    = (state_q == FILL) && (wb_ack || wb_err);

    always_comb begin
        hit_line = '0;
        vic      = rr_q[idx_q];
        for (int w = 0; w < WAYS; w++) begin
            hit_vec[w] = valid_q[w][idx_q] && (tag_rd[w] == tag_q);
            if (hit_vec[w]) hit_line = line_rd[w];
        end
        // Walk downward so the lowest invalid way wins.
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (!valid_q[w][idx_q]) vic = WAY_W'(w);
        end
        hit_any = (|hit_vec) && !mem_flush && !flush_prev_q;
        fill_line = lbuf_q;
        fill_line[LINE_W-1 -: 16] = wb_i_dat;
    end

    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        cnt_d        = cnt_q;
        lbuf_d       = lbuf_q;
        err_d        = err_q;
        disc_d       = disc_q;
        victim_d     = victim_q;
        valid_d      = valid_q;
        rr_d         = rr_q;
        flush_prev_d = mem_flush;
        mem_ack      = 1'b0;
        mem_err      = 1'b0;
        mem_data     = '0;
        wb_cyc       = 1'b0;
        wb_stb       = 1'b0;
        wr_en        = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (mem_req) begin
                    addr_d  = mem_addr;
                    state_d = LOOKUP;
                end
            end
            LOOKUP: begin
                if (hit_any) begin
                    mem_ack  = 1'b1;
                    mem_data = hit_line[32*off_q +: 32];
                    state_d  = IDLE;
                end else begin
                    victim_d = vic;
                    cnt_d    = '0;
                    err_d    = 1'b0;
                    disc_d   = 1'b0;
                    state_d  = FILL;
                end
            end
            FILL: begin
                wb_cyc = 1'b1;
                wb_stb = 1'b1;
                if (mem_flush) disc_d = 1'b1;
                if (beat) begin
                    lbuf_d[16*cnt_q +: 16] = wb_i_dat;
                    cnt_d = cnt_q + 1'b1;
                    err_d = err_q | wb_err;
                    if (cnt_q == LAST_BEAT) begin
                        mem_ack  = 1'b1;
                        mem_err  = err_q | wb_err;
                        mem_data = fill_line[32*off_q +: 32];
                        state_d  = IDLE;
                        if (!err_q && !wb_err && !disc_q && !mem_flush) begin
                            wr_en = 1'b1;
                            valid_d[victim_q][idx_q] = 1'b1;
                            rr_d[idx_q] = WAY_W'((32'(rr_q[idx_q]) + 1) % WAYS);
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        // Flush beats a same-edge commit.
        if (mem_flush) valid_d = '0;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q      <= IDLE;
            addr_q       <= '0;
            cnt_q        <= '0;
            lbuf_q       <= '0;
            err_q        <= 1'b0;
            disc_q       <= 1'b0;
            flush_prev_q <= 1'b0;
            victim_q     <= '0;
            valid_q      <= '0;
            rr_q         <= '0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            cnt_q        <= cnt_d;
            lbuf_q       <= lbuf_d;
            err_q        <= err_d;
            disc_q       <= disc_d;
            flush_prev_q <= flush_prev_d;
            victim_q     <= victim_d;
            valid_q      <= valid_d;
            rr_q         <= rr_d;
        end
    end

    always_ff @(posedge i_clk) begin
        for (int w = 0; w < WAYS; w++) begin
            if (rd_en) begin
                tag_rd[w]  <= tag_mem[w][rd_idx];
                line_rd[w] <= line_mem[w][rd_idx];
            end
        end
        if (wr_en) begin
            tag_mem[victim_q][idx_q]  <= tag_q;
            line_mem[victim_q][idx_q] <= fill_line;
        end
    end

`ifdef ICACHE_PERF_CNT_EN
    logic [15:0] ph_q, ph_d, pm_q, pm_d;

    always_comb begin
        ph_d = ph_q;
        pm_d = pm_q;
        if (state_q == LOOKUP) begin
            if (hit_any) begin
                if (ph_q != 16'hFFFF) ph_d = ph_q + 16'd1;
            end else begin
                if (pm_q != 16'hFFFF) pm_d = pm_q + 16'd1;
            end
        end
        if (mem_flush) begin
            ph_d = '0;
            pm_d = '0;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            ph_q <= '0;
            pm_q <= '0;
        end else begin
            ph_q <= ph_d;
            pm_q <= pm_d;
        end
    end

    assign perf_hit  = ph_q;
    assign perf_miss = pm_q;
`endif
endmodule

// File: tb/tb_icache_assoc.sv
// Directed bench for icache_assoc: zero-wait Wishbone slave returning
// word(a) = a ^ 16'h5A00, with optional error injection on one beat.
module tb_icache_assoc;
    logic        clk;
    logic        i_rst_n;
    logic        mem_req;
    logic [15:0] mem_addr;
    logic        mem_ack;
    logic [31:0] mem_data;
    logic        mem_err;
    logic        mem_flush;
    logic        wb_cyc, wb_stb, wb_we;
    logic [1:0]  wb_sel;
    logic [15:0] wb_adr;
    logic [15:0] wb_i_dat;
    logic        wb_ack, wb_err;
    logic [3:0]  err_beat;
`ifdef ICACHE_PERF_CNT_EN
    logic [15:0] perf_hit, perf_miss;
`endif

    int checks = 0;
    int errors = 0;
    int beats = 0;
    logic [15:0] adr_log [16];
    logic [15:0] first_adr, last_adr;
    int nb;

    icache_assoc dut (
        .i_clk     (clk),
        .i_rst_n   (i_rst_n),
        .mem_req   (mem_req),
        .mem_addr  (mem_addr),
        .mem_ack   (mem_ack),
        .mem_data  (mem_data),
        .mem_err   (mem_err),
        .mem_flush (mem_flush),
        .wb_cyc    (wb_cyc),
        .wb_stb    (wb_stb),
        .wb_we     (wb_we),
        .wb_sel    (wb_sel),
        .wb_adr    (wb_adr),
        .wb_i_dat  (wb_i_dat),
        .wb_ack    (wb_ack),
        .wb_err    (wb_err)
`ifdef ICACHE_PERF_CNT_EN
        ,
        .perf_hit  (perf_hit),
        .perf_miss (perf_miss)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign wb_i_dat = wb_adr ^ 16'h5A00;
    assign wb_err   = wb_cyc && wb_stb && (err_beat == {1'b0, wb_adr[2:0]});
    assign wb_ack   = wb_cyc && wb_stb && !wb_err;

    always @(posedge clk) begin
        if (wb_cyc && wb_stb && (wb_ack || wb_err)) begin
            adr_log[beats % 16] = wb_adr;
            beats = beats + 1;
        end
    end

    function automatic logic [31:0] exp_ins(input logic [15:0] a);
        logic [15:0] wa;
        wa = {a[14:0], 1'b0};
        return {(wa + 16'd1) ^ 16'h5A00, wa ^ 16'h5A00};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic access(input logic [15:0] a, input int flush_at,
                          output int lat, output logic [31:0] dat,
                          output logic er);
        int b0;
        lat = 0;
        dat = 'x;
        er  = 'x;
        @(negedge clk);
        b0 = beats;
        mem_addr = a;
        mem_req  = 1'b1;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            mem_flush = (c == flush_at);
            if (mem_ack) begin
                lat = c;
                dat = mem_data;
                er  = mem_err;
                break;
            end
        end
        mem_req = 1'b0;
        @(posedge clk);
        #1;
        nb = beats - b0;
        first_adr = adr_log[b0 % 16];
        last_adr  = adr_log[(beats + 15) % 16];
        if (mem_flush) begin
            @(negedge clk);
            mem_flush = 1'b0;
        end
    endtask

    task automatic acc_chk(input string tag, input logic [15:0] a,
                           input int exp_lat);
        int lat;
        logic [31:0] dat;
        logic er;
        access(a, 0, lat, dat, er);
        chk({tag, "_lat"}, lat, exp_lat);
        chk({tag, "_data"}, dat, exp_ins(a));
        chk({tag, "_err"}, {31'd0, er}, 32'd0);
        chk({tag, "_beats"}, nb, (exp_lat == 1) ? 0 : 8);
    endtask

    initial begin
        int lat;
        logic [31:0] dat;
        logic er;
        logic found;
        i_rst_n   = 1'b0;
        mem_req   = 1'b0;
        mem_addr  = '0;
        mem_flush = 1'b0;
        err_beat  = 4'd8;
        repeat (2) @(negedge clk);
        chk("rst_ack", {31'd0, mem_ack}, 32'd0);
        chk("rst_err", {31'd0, mem_err}, 32'd0);
        chk("rst_data", mem_data, 32'd0);
        chk("rst_cyc", {30'd0, wb_cyc, wb_stb}, 32'd0);
        chk("tie_we", {31'd0, wb_we}, 32'd0);
        chk("tie_sel", {30'd0, wb_sel}, 32'd3);
        i_rst_n = 1'b1;

        // Cold miss then hits on the same line.
        access(16'h0004, 0, lat, dat, er);
        chk("cold_lat", lat, 9);
        chk("cold_data", dat, 32'h5A095A08);
        chk("cold_err", {31'd0, er}, 32'd0);
        chk("cold_beats", nb, 8);
        chk("cold_first_adr", {16'd0, first_adr}, 32'h0008);
        chk("cold_last_adr", {16'd0, last_adr}, 32'h000F);
        acc_chk("rep_hit", 16'h0004, 1);
        access(16'h0005, 0, lat, dat, er);
        chk("hit_off1", dat, 32'h5A0B5A0A);
        acc_chk("hit_off3", 16'h0007, 1);

        // Set 0 replacement: fill ways 0..3, then round-robin.
        acc_chk("t1_fill", 16'h0080, 9);
        acc_chk("t2_fill", 16'h0100, 9);
        acc_chk("t3_fill", 16'h0180, 9);
        acc_chk("t4_fill", 16'h0200, 9);
        acc_chk("t1_hit", 16'h0080, 1);
        acc_chk("t5_fill", 16'h0280, 9);
        acc_chk("t2_hit_a", 16'h0100, 1);
        acc_chk("t3_hit_a", 16'h0180, 1);
        acc_chk("t4_hit_a", 16'h0200, 1);
        acc_chk("t5_hit", 16'h0280, 1);
        acc_chk("t6_fill", 16'h0300, 9);
        acc_chk("t3_hit_b", 16'h0180, 1);
        acc_chk("t5_hit_b", 16'h0280, 1);
        acc_chk("t6_hit", 16'h0300, 1);
        acc_chk("t1_refill", 16'h0080, 9);
        acc_chk("t4_hit_c", 16'h0200, 1);
        acc_chk("t3_evicted", 16'h0180, 9);

        // Bus error mid-burst and on the last beat.
        err_beat = 4'd3;
        access(16'h0404, 0, lat, dat, er);
        chk("err3_lat", lat, 9);
        chk("err3_err", {31'd0, er}, 32'd1);
        chk("err3_beats", nb, 8);
        err_beat = 4'd7;
        access(16'h0484, 0, lat, dat, er);
        chk("err7_lat", lat, 9);
        chk("err7_err", {31'd0, er}, 32'd1);
        err_beat = 4'd8;
        acc_chk("err3_refetch", 16'h0404, 9);
        acc_chk("err3_hit", 16'h0404, 1);
        acc_chk("err7_refetch", 16'h0484, 9);

        // Flush mid-fill and flush on the commit edge.
        access(16'h0808, 4, lat, dat, er);
        chk("flfill_lat", lat, 9);
        chk("flfill_data", dat, 32'h4A114A10);
        chk("flfill_err", {31'd0, er}, 32'd0);
        acc_chk("flfill_miss", 16'h0808, 9);
        acc_chk("flfill_hit", 16'h0808, 1);
        access(16'h0C00, 9, lat, dat, er);
        chk("flcommit_data", dat, 32'h42014200);
        acc_chk("flcommit_miss", 16'h0C00, 9);

        // Flush while idle invalidates everything.
        @(negedge clk);
        mem_flush = 1'b1;
        @(negedge clk);
        mem_flush = 1'b0;
        acc_chk("idlefl_a", 16'h0808, 9);
        acc_chk("idlefl_b", 16'h0300, 9);
        acc_chk("idlefl_c", 16'h0004, 9);

        // Reset asserted while beat 4 is on the bus.
        @(negedge clk);
        mem_addr = 16'h1000;
        mem_req  = 1'b1;
        found    = 1'b0;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (wb_cyc && wb_adr[2:0] == 3'd4) begin
                found = 1'b1;
                break;
            end
        end
        chk("rstfill_beat4", {31'd0, found}, 32'd1);
        i_rst_n = 1'b0;
        mem_req = 1'b0;
        #1;
        chk("rstfill_cyc", {30'd0, wb_cyc, wb_stb}, 32'd0);
        chk("rstfill_ack", {31'd0, mem_ack}, 32'd0);
        @(negedge clk);
        i_rst_n = 1'b1;
        found = 1'b0;
        repeat (4) begin
            @(negedge clk);
            if (mem_ack || wb_cyc) found = 1'b1;
        end
        chk("rstfill_idle", {31'd0, found}, 32'd0);

        // Valid bits cleared by reset; then 3 hits and 2 misses.
        acc_chk("post_rst_miss", 16'h0004, 9);
        acc_chk("post_rst_hit0", 16'h0004, 1);
        acc_chk("post_rst_hit1", 16'h0005, 1);
        acc_chk("post_rst_hit2", 16'h0006, 1);
        acc_chk("post_rst_miss2", 16'h0808, 9);
`ifdef ICACHE_PERF_CNT_EN
        chk("perf_hit", {16'd0, perf_hit}, 32'd3);
        chk("perf_miss", {16'd0, perf_miss}, 32'd2);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
